// File: rtl/rgbw_spi_frame_rx.sv
// SPI mode-1 slave byte recovery plus framed, XOR-checksummed NUM_CH-byte payload parser.
// ch_data only moves on frame_valid, so downstream PWM never sees a partial frame.
module rgbw_spi_frame_rx #(
  parameter int          NUM_CH      = 6,
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter logic [7:0]  CHK_SEED    = 8'h00,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                  clk12,
  input  logic                  reset,
  input  logic                  sck0,
  input  logic                  mosi,
  input  logic                  cs,
  output logic [8*NUM_CH-1:0]   ch_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [7:0]            rx_byte,
  output logic                  rx_byte_valid,
  output logic                  busy
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  logic [2:0] sck_s;
  logic [1:0] mosi_s, cs_s;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       sck_fall;
  logic [7:0] nxt_byte;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [7:0]             chk;
  logic [TW-1:0]          timer;
  logic [NUM_CH-1:0][7:0] shadow;

  assign sck_fall = sck_s[2] & ~sck_s[1];
  assign nxt_byte = {shreg[6:0], mosi_s[1]};
  assign busy     = (state != HUNT);

  // cs synchroniser idles high so nothing is captured straight out of reset
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      sck_s  <= '0;
      mosi_s <= '0;
      cs_s   <= 2'b11;
    end else begin
      sck_s  <= {sck_s[1:0], sck0};
      mosi_s <= {mosi_s[0], mosi};
      cs_s   <= {cs_s[0], cs};
    end
  end

  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= '0;
      end else if (sck_fall) begin
        shreg   <= nxt_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte       <= nxt_byte;
          rx_byte_valid <= 1'b1;
        end
      end
    end
  end

  // An arriving byte always wins over a timeout in the same cycle.
  always_ff @(posedge clk12 or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      idx         <= '0;
      chk         <= '0;
      timer       <= '0;
      shadow      <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (rx_byte_valid) begin
        timer <= '0;
        case (state)
          HUNT: if (rx_byte == SYNC_BYTE) begin
            state <= DATA;
            idx   <= '0;
            chk   <= CHK_SEED;
          end
          DATA: begin
            shadow[idx] <= rx_byte;
            chk         <= chk ^ rx_byte;
            if (idx == LAST_IDX) state <= CHECK;
            else                 idx   <= idx + 1'b1;
          end
          CHECK: begin
            if (rx_byte == chk) begin
              ch_data     <= shadow;
              frame_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state == HUNT) begin
        timer <= '0;
      end else if (timer == TO_VAL) begin
        state     <= HUNT;
        frame_err <= 1'b1;
        shadow    <= '0;
        timer     <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rgbw_spi_frame_rx.sv
// Randomised SPI frames against a queue-based scoreboard; expected events come from the
// frame contents the bench chooses (XOR of payload), checked by an independent monitor.
module tb_rgbw_spi_frame_rx;
  localparam int NUM_CH = 6;
  localparam int TO     = 4096;
  localparam logic [7:0] SYNC = 8'h55;

  typedef logic [NUM_CH-1:0][7:0] pay_t;
  typedef struct packed { logic err; logic [8*NUM_CH-1:0] data; } ev_t;

  logic clk12 = 1'b0, reset = 1'b0, sck0 = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic [8*NUM_CH-1:0] ch_data;
  logic frame_valid, frame_err, rx_byte_valid, busy;
  logic [7:0] rx_byte;

  ev_t        exp_q[$];
  logic [7:0] byte_q[$];
  int total = 0, bad = 0, nrx = 0;
  logic [8*NUM_CH-1:0] model_ch = '0;

  rgbw_spi_frame_rx #(.NUM_CH(NUM_CH), .SYNC_BYTE(SYNC), .CHK_SEED(8'h00), .TIMEOUT_CYC(TO)) dut (
    .clk12(clk12), .reset(reset), .sck0(sck0), .mosi(mosi), .cs(cs),
    .ch_data(ch_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .busy(busy));

  always #5 clk12 = ~clk12;

  task automatic report(input string name, input logic [63:0] act, input logic [63:0] exp);
    bad++;
    $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) report(name, act, exp);
  endtask

  // Monitor: pops expected bytes and frame events whenever the DUT presents them.
  always @(negedge clk12) begin
    if (!reset) begin
      model_ch = '0;
    end else begin
      if (frame_valid && frame_err) begin total++; report("both_pulses", 1, 0); end
      if (rx_byte_valid) begin
        nrx++;
        total++;
        if (byte_q.size() == 0) report("rx_byte_unexpected", {56'd0, rx_byte}, 0);
        else begin
          logic [7:0] eb;
          eb = byte_q.pop_front();
          if (rx_byte !== eb) report("rx_byte", {56'd0, rx_byte}, {56'd0, eb});
        end
      end
      if (frame_valid || frame_err) begin
        total++;
        if (exp_q.size() == 0) report("event_unexpected", {62'd0, frame_err, frame_valid}, 0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          if (frame_err !== e.err) report("event_kind_err", {63'd0, frame_err}, {63'd0, e.err});
          if (!e.err) model_ch = e.data;
          total++;
          if (ch_data !== model_ch) report("ch_data_event", {16'd0, ch_data}, {16'd0, model_ch});
        end
      end else begin
        total++;
        if (ch_data !== model_ch) report("ch_data_hold", {16'd0, ch_data}, {16'd0, model_ch});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int half;
    half = $urandom_range(35, 70);
    byte_q.push_back(b);
    cs = 1'b0;
    #(half);
    for (int i = 7; i >= 0; i--) begin
      sck0 = 1'b1; mosi = b[i]; #(half);
      sck0 = 1'b0; #(half);
    end
    cs = 1'b1;
    #($urandom_range(40, 100));
  endtask

  task automatic send_partial(input int n);
    int half;
    half = $urandom_range(35, 70);
    cs = 1'b0;
    #(half);
    for (int i = 0; i < n; i++) begin
      sck0 = 1'b1; mosi = $urandom_range(0, 1); #(half);
      sck0 = 1'b0; #(half);
    end
    cs = 1'b1;
    #(100);
  endtask

  // Expected outcome comes straight from the frame definition: XOR of payload bytes.
  task automatic send_frame(input pay_t p, input bit good);
    logic [7:0] c;
    ev_t e;
    c = 8'h00;
    for (int i = 0; i < NUM_CH; i++) c ^= p[i];
    if (!good) c ^= 8'($urandom_range(1, 255));
    e.err  = !good;
    e.data = p;
    exp_q.push_back(e);
    send_byte(SYNC);
    for (int i = 0; i < NUM_CH; i++) send_byte(p[i]);
    send_byte(c);
  endtask

  task automatic wait_drain(input string name, input int cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_q.size() != 0) && n < cycles) begin
      @(negedge clk12);
      n++;
    end
    repeat (3) @(negedge clk12);
    total++;
    if (exp_q.size() != 0 || byte_q.size() != 0)
      report({name, "_timeout"}, 64'(exp_q.size()), 64'(byte_q.size()));
  endtask

  task automatic check_zero(input string name);
    check({name, "_ch"},  {16'd0, ch_data}, 0);
    check({name, "_fv"},  {63'd0, frame_valid}, 0);
    check({name, "_fe"},  {63'd0, frame_err}, 0);
    check({name, "_rxb"}, {56'd0, rx_byte}, 0);
    check({name, "_rxv"}, {63'd0, rx_byte_valid}, 0);
    check({name, "_busy"}, {63'd0, busy}, 0);
  endtask

  initial begin
    pay_t p1, p4, p;
    int n0;
    ev_t e;
    p1 = {8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
    p4 = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    repeat (3) @(negedge clk12);
    check_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk12);

    // 1: valid frame
    send_frame(p1, 1'b1);
    wait_drain("t1", 2000);
    check("t1_ch_data", {16'd0, ch_data}, {16'd0, 48'h605040302010});

    // 2: bad checksum 71
    exp_q.push_back('{err: 1'b1, data: '0});
    send_byte(SYNC);
    for (int i = 0; i < NUM_CH; i++) send_byte(p1[i]);
    send_byte(8'h71);
    wait_drain("t2", 2000);
    check("t2_busy", {63'd0, busy}, 0);
    check("t2_ch_hold", {16'd0, ch_data}, {16'd0, 48'h605040302010});

    // 3: garbage then frame (new data so the update is visible)
    send_byte(8'h00); send_byte(8'hA4); send_byte(8'hFF);
    check("t3_busy_garbage", {63'd0, busy}, 0);
    send_frame(p4, 1'b1);
    wait_drain("t3a", 2000);
    send_frame(p1, 1'b1);
    wait_drain("t3", 2000);

    // 4: timeout mid-frame
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h20);
    wait_drain("t4_bytes", 200);
    check("t4_busy_mid", {63'd0, busy}, 1);
    exp_q.push_back('{err: 1'b1, data: '0});
    wait_drain("t4_timeout", TO + 10);
    check("t4_busy_after", {63'd0, busy}, 0);
    send_frame(p4, 1'b1);
    wait_drain("t4", 2000);
    check("t4_ch_data", {16'd0, ch_data}, {16'd0, 48'h060504030201});

    // 5: partial byte discarded
    n0 = nrx;
    send_partial(4);
    send_frame(p1, 1'b1);
    wait_drain("t5", 2000);
    check("t5_rx_count", 64'(nrx - n0), 64'(NUM_CH + 2));
    check("t5_ch_data", {16'd0, ch_data}, {16'd0, 48'h605040302010});

    // 6: reset mid-frame
    send_byte(SYNC); send_byte(8'h10); send_byte(8'h20);
    wait_drain("t6_bytes", 200);
    reset = 1'b0;
    repeat (5) @(negedge clk12);
    check_zero("t6_in_reset");
    reset = 1'b1;
    @(negedge clk12);
    check_zero("t6_after");
    send_frame(p4, 1'b1);
    wait_drain("t6", 2000);
    check("t6_ch_data", {16'd0, ch_data}, {16'd0, 48'h060504030201});

    // Random frames with occasional garbage and bad checksums
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == SYNC) g = 8'h54;
        send_byte(g);
      end
      for (int i = 0; i < NUM_CH; i++) p[i] = 8'($urandom);
      send_frame(p, $urandom_range(0, 3) != 0);
      wait_drain("rand", 2000);
    end

    check("final_exp_q_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
